// File: rtl/lcd_pkg.sv
// Shared types and default strobe timing for the SPI-to-LCD bridge.
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PULSE = 2'd2,
    ST_HOLD  = 2'd3
  } lcd_state_e;

  localparam int LCD_SETUP_CYC = 2;
  localparam int LCD_PULSE_CYC = 4;
  localparam int LCD_HOLD_CYC  = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lcd_sync_fifo.sv
// Single-clock receive FIFO between the SPI deserialiser and the LCD strobe FSM.
module lcd_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // push is honoured when not full, or when full and popping in the same cycle;
  // pop is ignored when empty. dout always shows the head word.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lcd_spi_bridge.sv
// SPI slave feeding a FIFO of {data,rs} words that are strobed onto an HD44780-style bus.
// Optional sticky overrun flag OVR is built only when LCD_SPI_OVR_EN is defined.
module lcd_spi_bridge
  import lcd_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int SETUP_CYC = LCD_SETUP_CYC,
  parameter int PULSE_CYC = LCD_PULSE_CYC,
  parameter int HOLD_CYC  = LCD_HOLD_CYC
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SSEL,
  input  logic              SCK,
  input  logic              MOSI,
  output logic [DATA_W-1:0] DLCD,
  output logic              RS,
  output logic              E,
  output logic              LCD_LE,
  output logic              BUSY,
  output lcd_state_e        STATE
`ifdef LCD_SPI_OVR_EN
  ,
  output logic              OVR
`endif
);
  localparam int BW = $clog2(DATA_W + 1);
  localparam int CW = $clog2(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC) + 1);
  localparam int AW = $clog2(DEPTH);

  logic [1:0]      ssel_sy, sck_sy, mosi_sy;
  logic            sck_d;
  logic            sck_rise;
  logic [BW-1:0]   bit_cnt;
  logic [DATA_W:0] shreg;
  logic [DATA_W:0] push_word;
  logic [DATA_W:0] pop_word;
  logic            push, push_ok, pop;
  logic            fifo_full, fifo_empty;
  logic [AW:0]     fifo_count;
  logic            fifo_nz_nxt;
  logic [CW-1:0]   cyc;

  assign sck_rise  = sck_sy[1] & ~sck_d;
  // Shift right so that after DATA_W+1 bits frame bit 0 (rs) lands in bit 0.
  assign push_word = {mosi_sy[1], shreg[DATA_W:1]};
  assign push      = sck_rise & ~ssel_sy[1] & (bit_cnt == BW'(DATA_W)) & ~RST;
  assign push_ok   = push & (~fifo_full | pop);
  assign pop       = (STATE == ST_IDLE) & ~fifo_empty & ~RST;
  assign fifo_nz_nxt = push_ok | (fifo_count > (AW+1)'(1)) |
                       ((fifo_count == (AW+1)'(1)) & ~pop);

  always_ff @(posedge CLK) begin
    if (RST) begin
      ssel_sy <= 2'b11;
      sck_sy  <= 2'b00;
      mosi_sy <= 2'b00;
      sck_d   <= 1'b0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      ssel_sy <= {ssel_sy[0], SSEL};
      sck_sy  <= {sck_sy[0], SCK};
      mosi_sy <= {mosi_sy[0], MOSI};
      sck_d   <= sck_sy[1];
      if (ssel_sy[1]) begin
        bit_cnt <= '0;
      end else if (sck_rise) begin
        shreg   <= push_word;
        bit_cnt <= (bit_cnt == BW'(DATA_W)) ? '0 : bit_cnt + 1'b1;
      end
    end
  end

  lcd_sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push_ok),
    .pop   (pop),
    .din   (push_word),
    .dout  (pop_word),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // BUSY is registered from next-cycle state and FIFO occupancy so it tracks exactly.
  always_ff @(posedge CLK) begin
    if (RST) begin
      STATE  <= ST_IDLE;
      cyc    <= '0;
      DLCD   <= '0;
      RS     <= 1'b1;
      E      <= 1'b1;
      LCD_LE <= 1'b0;
      BUSY   <= 1'b0;
    end else begin
      case (STATE)
        ST_IDLE: begin
          if (pop) begin
            DLCD  <= pop_word[DATA_W:1];
            RS    <= ~pop_word[0];
            STATE <= ST_SETUP;
            cyc   <= '0;
            BUSY  <= 1'b1;
          end else begin
            BUSY  <= fifo_nz_nxt;
          end
        end
        ST_SETUP: begin
          BUSY <= 1'b1;
          if (cyc == CW'(SETUP_CYC - 1)) begin
            STATE  <= ST_PULSE;
            cyc    <= '0;
            LCD_LE <= 1'b1;
            E      <= 1'b0;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        ST_PULSE: begin
          BUSY <= 1'b1;
          if (cyc == CW'(PULSE_CYC - 1)) begin
            STATE  <= ST_HOLD;
            cyc    <= '0;
            LCD_LE <= 1'b0;
            E      <= 1'b1;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        ST_HOLD: begin
          if (cyc == CW'(HOLD_CYC - 1)) begin
            STATE <= ST_IDLE;
            cyc   <= '0;
            BUSY  <= fifo_nz_nxt;
          end else begin
            cyc  <= cyc + 1'b1;
            BUSY <= 1'b1;
          end
        end
        default: STATE <= ST_IDLE;
      endcase
    end
  end

`ifdef LCD_SPI_OVR_EN
  always_ff @(posedge CLK) begin
    if (RST) OVR <= 1'b0;
    else if (push & ~push_ok) OVR <= 1'b1;
  end
`endif

endmodule
